// File: rtl/vx_fp_rounder_if.sv
// Beat-level handshake bundle for vx_fp_rounder: unrounded operand in, packed result out.
interface vx_fp_rounder_if #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 7,
    parameter int unsigned TAG_W = 4
);
    logic                 valid_in;
    logic                 ready_in;
    logic                 sign_in;
    logic [EXP_W+1:0]     exp_in;
    logic [MAN_W+2:0]     man_in;
    logic [2:0]           frm_in;
    logic [TAG_W-1:0]     tag_in;
    logic                 valid_out;
    logic                 ready_out;
    logic [EXP_W+MAN_W:0] result_out;
    logic [2:0]           fflags_out;
    logic [TAG_W-1:0]     tag_out;

    modport master (
        output valid_in, sign_in, exp_in, man_in, frm_in, tag_in, ready_out,
        input  ready_in, valid_out, result_out, fflags_out, tag_out
    );

    modport slave (
        input  valid_in, sign_in, exp_in, man_in, frm_in, tag_in, ready_out,
        output ready_in, valid_out, result_out, fflags_out, tag_out
    );
endinterface

// File: rtl/vx_fp_rounder.sv
// Two-stage FP rounder: S1 rounds and normalises the carry, S2 range-checks, saturates and packs.
// Define VX_FP_ROUNDER_FFLAGS_EN to compute and register {OF, UF, NX}; otherwise fflags_out is 0.
module vx_fp_rounder #(
    parameter int unsigned EXP_W = 8,
    parameter int unsigned MAN_W = 7,
    parameter int unsigned TAG_W = 4
) (
    input  logic           clk,
    input  logic           reset,
    vx_fp_rounder_if.slave io
);
    localparam int unsigned XW   = EXP_W + 3;
    localparam int unsigned MW   = MAN_W + 2;
    localparam int unsigned BIAS = (32'd1 << (EXP_W - 1)) - 32'd1;

    localparam logic signed [XW-1:0] EXP_MAX = XW'(BIAS);
    localparam logic signed [XW-1:0] EXP_MIN = XW'(1) - EXP_MAX;

    localparam logic [2:0] FRM_RTZ = 3'd1;
    localparam logic [2:0] FRM_RDN = 3'd2;
    localparam logic [2:0] FRM_RUP = 3'd3;
    localparam logic [2:0] FRM_RMM = 3'd4;

    logic                    w_en;
    logic                    w_rnd;
    logic                    w_stk;
    logic                    w_lsb;
    logic                    w_inc;
    logic                    w_carry;
    logic [MW-1:0]           w_sum;
    logic [MAN_W-1:0]        w_frac;
    logic signed [XW-1:0]    w_exp;

    logic                    r_s1_valid;
    logic                    r_s1_sign;
    logic signed [XW-1:0]    r_s1_exp;
    logic [MAN_W-1:0]        r_s1_frac;
    logic [2:0]              r_s1_frm;
    logic [TAG_W-1:0]        r_s1_tag;

    logic                    w_of;
    logic                    w_uf;
    logic                    w_to_inf;
    logic [EXP_W-1:0]        w_exp_field;
    logic [EXP_W+MAN_W:0]    w_result;

    logic                    r_valid_out;
    logic [EXP_W+MAN_W:0]    r_result;
    logic [TAG_W-1:0]        r_tag_out;

    // Whole pipe advances together; it only holds when a finished result is refused.
    assign w_en        = !(r_valid_out && !io.ready_out);
    assign io.ready_in = w_en;

    assign w_rnd = io.man_in[1];
    assign w_stk = io.man_in[0];
    assign w_lsb = io.man_in[2];

    always_comb begin
        w_inc = 1'b0;
        case (io.frm_in)
            FRM_RTZ: w_inc = 1'b0;
            FRM_RDN: w_inc = io.sign_in & (w_rnd | w_stk);
            FRM_RUP: w_inc = ~io.sign_in & (w_rnd | w_stk);
            FRM_RMM: w_inc = w_rnd;
            default: w_inc = w_rnd & (w_stk | w_lsb);
        endcase
    end

    // A carry out of the significand only happens at exactly 2^(MAN_W+1), so the fraction is then zero.
    assign w_sum   = {1'b0, io.man_in[MAN_W+2:2]} + MW'(w_inc);
    assign w_carry = w_sum[MW-1];
    assign w_frac  = w_carry ? w_sum[MAN_W:1] : w_sum[MAN_W-1:0];
    assign w_exp   = {io.exp_in[EXP_W+1], io.exp_in} + XW'(w_carry);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_exp   <= '0;
            r_s1_frac  <= '0;
            r_s1_frm   <= '0;
            r_s1_tag   <= '0;
        end else if (w_en) begin
            r_s1_valid <= io.valid_in;
            r_s1_sign  <= io.sign_in;
            r_s1_exp   <= w_exp;
            r_s1_frac  <= w_frac;
            r_s1_frm   <= io.frm_in;
            r_s1_tag   <= io.tag_in;
        end
    end

    assign w_of        = r_s1_exp > EXP_MAX;
    assign w_uf        = r_s1_exp < EXP_MIN;
    assign w_exp_field = EXP_W'(r_s1_exp + XW'(BIAS));

    // Overflow goes to infinity unless the mode rounds toward zero for this sign.
    always_comb begin
        w_to_inf = 1'b1;
        case (r_s1_frm)
            FRM_RTZ: w_to_inf = 1'b0;
            FRM_RDN: w_to_inf = r_s1_sign;
            FRM_RUP: w_to_inf = ~r_s1_sign;
            default: w_to_inf = 1'b1;
        endcase
        w_result = {r_s1_sign, w_exp_field, r_s1_frac};
        if (w_of) begin
            w_result = w_to_inf ? {r_s1_sign, {EXP_W{1'b1}}, {MAN_W{1'b0}}}
                                : {r_s1_sign, {(EXP_W-1){1'b1}}, 1'b0, {MAN_W{1'b1}}};
        end else if (w_uf) begin
            w_result = {r_s1_sign, {(EXP_W+MAN_W){1'b0}}};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_valid_out <= 1'b0;
            r_result    <= '0;
            r_tag_out   <= '0;
        end else if (w_en) begin
            r_valid_out <= r_s1_valid;
            r_result    <= w_result;
            r_tag_out   <= r_s1_tag;
        end
    end

    assign io.valid_out  = r_valid_out;
    assign io.result_out = r_result;
    assign io.tag_out    = r_tag_out;

`ifdef VX_FP_ROUNDER_FFLAGS_EN
    logic       r_s1_nx;
    logic [2:0] r_fflags;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_s1_nx <= 1'b0;
        end else if (w_en) begin
            r_s1_nx <= w_rnd | w_stk;
        end
    end

    // Saturation and flush-to-zero are always inexact.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_fflags <= '0;
        end else if (w_en) begin
            r_fflags <= {w_of, w_uf, w_of | w_uf | r_s1_nx};
        end
    end

    assign io.fflags_out = r_fflags;
`else
    assign io.fflags_out = 3'b000;
`endif

endmodule

// File: doc/vx_fp_rounder.md
VX_FP_ROUNDER -- requirements
Module: VX_fp_rounder

Interface
REQ-001 SHALL have parameter EXP_W, default 8, exponent field width.
REQ-002 SHALL have parameter MAN_W, default 7, stored fraction width; defaults give bfloat16.
REQ-003 SHALL have parameter TAG_W, default 4, passthrough tag width.
REQ-004 SHALL have port clk  input  1  single clock; all logic on rising edge.
REQ-005 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-006 SHALL have port valid_in  input  1  input beat valid.
REQ-007 SHALL have port ready_in  output  1  block accepts beat.
REQ-008 SHALL have port sign_in  input  1  operand sign.
REQ-009 SHALL have port exp_in  input  EXP_W+2  signed unbiased exponent.
REQ-010 SHALL have port man_in  input  MAN_W+3  bits: [MAN_W+2] hidden, [MAN_W+1:2] fraction, [1] round, [0] sticky.
REQ-011 SHALL have port frm_in  input  3  rounding mode: 0 RNE, 1 RTZ, 2 RDN, 3 RUP, 4 RMM; 5-7 treated as RNE.
REQ-012 SHALL have port tag_in  input  TAG_W  opaque tag.
REQ-013 SHALL have port valid_out  output  1  result valid.
REQ-014 SHALL have port ready_out  input  1  consumer accepts result.
REQ-015 SHALL have port result_out  output  1+EXP_W+MAN_W  packed {sign, biased exp, fraction}.
REQ-016 SHALL have port fflags_out  output  3  {OF, UF, NX}.
REQ-017 SHALL have port tag_out  output  TAG_W  tag of result beat.

Function
REQ-018 SHALL accept a beat on a clock where valid_in and ready_in are both high; SHALL present the result exactly 2 cycles later when no stall occurs.
REQ-019 SHALL implement two stages: S1 rounds and detects carry; S2 checks range, saturates and packs.
REQ-020 SHALL advance the pipeline when its enable = !(valid_out && !ready_out) is high; ready_in SHALL equal that enable; a stall SHALL freeze both stages and lose no beat.
REQ-021 SHALL compute increment inc from r=man_in[1], s=man_in[0], lsb=man_in[2]: RNE r&(s|lsb); RTZ 0; RDN sign&(r|s); RUP !sign&(r|s); RMM r.
REQ-022 SHALL form m = man_in[MAN_W+2:2] + inc; if m == 2^(MAN_W+1), SHALL shift m right 1 and add 1 to the exponent.
REQ-023 SHALL assert NX when r|s == 1.
REQ-024 SHALL use BIAS = 2^(EXP_W-1)-1; if the final exponent > BIAS, SHALL assert OF and NX and saturate.
REQ-025 On overflow, RNE/RMM SHALL give signed infinity and RTZ signed max-finite; RDN SHALL give +max-finite for positive and -inf for negative; RUP SHALL give +inf for positive and -max-finite for negative.
REQ-026 If the final exponent < 1-BIAS, SHALL output signed zero and assert UF and NX; subnormals are not produced.
REQ-027 Otherwise SHALL output {sign, exp+BIAS, m[MAN_W-1:0]}.
REQ-028 tag_out SHALL accompany its result beat unchanged; beats SHALL leave in acceptance order.

Reset
REQ-029 While reset is high, SHALL clear both stage valid bits, so that valid_out=0 on the following cycle.
REQ-030 During reset, result_out, fflags_out and tag_out SHALL be 0.
REQ-031 A reset mid-stream SHALL discard in-flight beats with no output.
REQ-032 ready_in SHALL be high in the first cycle after reset deasserts.

Configuration
REQ-033 With VX_FP_ROUNDER_FFLAGS_EN defined, fflags_out SHALL be computed per REQ-023..026 and registered with the result.
REQ-034 Without VX_FP_ROUNDER_FFLAGS_EN, fflags_out SHALL be tied to 0, no flag registers SHALL exist, and result_out behaviour SHALL be unchanged.

Verification
REQ-035 Exact case: exp 0, man 0x200, RNE -> result 0x3F80, flags 000.
REQ-036 Tie handling: man 0x202 -> RNE 0x3F80 / RMM 0x3F81; man 0x206 -> RNE 0x3F82; all NX=1.
REQ-037 Mantissa carry: exp 0, man 0x3FF, RNE -> 0x4000, NX=1.
REQ-038 Overflow saturation: exp 127, man 0x3FF, RNE -> 0x7F80, OF=NX=1; exp 128, man 0x200, sign 1, RTZ -> 0xFF7F, OF=1; same operand with RDN -> 0xFF80.
REQ-039 Backpressure: 4 back-to-back beats with ready_out low for 3 cycles -> ready_in drops once both stages are full; all 4 results emerge in order with correct tags.
REQ-040 Reset mid-stream: assert reset with 2 beats in flight -> no valid_out afterwards; a new beat returns after 2 cycles.
